// File: rtl/ebpc_pkg.sv
// Shared symbol code constants, types and length helper for the EBPC symbol decode path.
package ebpc_pkg;

  localparam int unsigned DATA_W_P     = 8;
  localparam int unsigned BLOCK_SIZE_P = 8;
  localparam int unsigned LOG_DATA_W_P = $clog2(DATA_W_P);
  localparam int unsigned LOG_N_P      = $clog2(BLOCK_SIZE_P - 1);

  // Prefix codes, MSB first; a leading '1' marks an uncompressed plane.
  localparam logic [1:0] CODE_DBX0   = 2'b01;
  localparam logic [2:0] CODE_RUN    = 3'b001;
  localparam logic [4:0] CODE_ONES   = 5'b00000;
  localparam logic [4:0] CODE_DBP0   = 5'b00001;
  localparam logic [4:0] CODE_PAIR   = 5'b00010;
  localparam logic [4:0] CODE_SINGLE = 5'b00011;

  typedef logic [LOG_DATA_W_P:0] symb_len_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PLANE,
    ST_RUN
  } state_e;

  function automatic int unsigned get_len(
    input logic [4:0]  prefix,
    input int unsigned log_data_w = LOG_DATA_W_P,
    input int unsigned log_n      = LOG_N_P,
    input int unsigned block_size = BLOCK_SIZE_P
  );
    if (prefix[4]) return block_size;
    if (prefix[4:3] == CODE_DBX0) return 2;
    if (prefix[4:2] == CODE_RUN) return 3 + log_data_w;
    if (prefix == CODE_ONES || prefix == CODE_DBP0) return 5;
    return 5 + log_n;
  endfunction

endpackage

// File: rtl/symbol_decoder_p_expander.sv
// Combinational symbol expander: decodes the MSB-aligned symbol into a left-aligned DBX word,
// the direct-zero flag, zero-run length and symbol length.
module expander_p
  import ebpc_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned BLOCK_SIZE = 8
) (
  input  logic [DATA_W-1:0]         data,
  output logic [DATA_W-1:0]         dbx,
  output logic                      is_dbp,
  output logic                      is_run,
  output logic [$clog2(DATA_W):0]   run_len,
  output logic [$clog2(DATA_W):0]   sym_len
);

  localparam int unsigned LOG_DATA_W = $clog2(DATA_W);
  localparam int unsigned LOG_N      = $clog2(BLOCK_SIZE - 1);
  localparam int unsigned PW         = BLOCK_SIZE - 1;
  localparam int unsigned PAD_W      = DATA_W - PW;

  typedef logic [LOG_DATA_W:0] len_t;

  logic [4:0]            prefix;
  logic [LOG_DATA_W-1:0] run_r;
  logic [LOG_N-1:0]      pos;
  logic [PW-1:0]         raw;
  logic [PW-1:0]         plane;

  assign prefix  = data[DATA_W-1 -: 5];
  assign run_r   = data[DATA_W-4 -: LOG_DATA_W];
  assign pos     = data[DATA_W-6 -: LOG_N];
  assign raw     = data[DATA_W-2 -: PW];
  assign sym_len = len_t'(get_len(prefix, LOG_DATA_W, LOG_N, BLOCK_SIZE));
  assign run_len = {1'b0, run_r} + 1'b1;

  // A pair at the top position shifts its second one past the plane and is dropped.
  always_comb begin
    plane  = '0;
    is_dbp = 1'b0;
    is_run = 1'b0;
    if (prefix[4]) begin
      plane = raw;
    end else if (prefix[4:3] == CODE_DBX0) begin
      plane = '0;
    end else if (prefix[4:2] == CODE_RUN) begin
      is_run = 1'b1;
    end else begin
      case (prefix)
        CODE_ONES:   plane = '1;
        CODE_DBP0:   is_dbp = 1'b1;
        CODE_PAIR:   plane = PW'(3) << pos;
        CODE_SINGLE: plane = PW'(1) << pos;
        default:     plane = '0;
      endcase
    end
  end

  assign dbx = {plane, {PAD_W{1'b0}}};

endmodule

// File: rtl/symbol_decoder_p.sv
// BPC symbol decoder: emits a base word then DATA_W+1 delta bitplanes per block.
// Optional sticky error output enabled by SYMBOL_DECODER_ERR_EN.
module symbol_decoder_p
  import ebpc_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned BLOCK_SIZE = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clr_i,
  input  logic [DATA_W-1:0]        data_i,
  input  logic [$clog2(DATA_W):0]  fill_i,
  input  logic                     data_vld_i,
  output logic                     data_rdy_o,
  output logic [$clog2(DATA_W):0]  len_o,
  output logic [DATA_W-1:0]        data_o,
  output logic                     base_o,
  output logic                     last_o,
  output logic                     vld_o,
  input  logic                     rdy_i
`ifdef SYMBOL_DECODER_ERR_EN
  ,
  output logic                     err_o
`endif
);

  localparam int unsigned LOG_DATA_W = $clog2(DATA_W);
  localparam int unsigned N_PLANES   = DATA_W + 1;

  typedef logic [LOG_DATA_W:0] cnt_t;

  localparam cnt_t LAST_PLANE = cnt_t'(N_PLANES - 1);
  localparam cnt_t FULL_LEN   = cnt_t'(DATA_W);

  state_e            state_q;
  cnt_t              plane_cnt_q;
  cnt_t              run_cnt_q;
  logic [DATA_W-1:0] dbp_q;

  logic [DATA_W-1:0] dbx;
  logic [DATA_W-1:0] dbp;
  logic              is_dbp;
  logic              is_run;
  cnt_t              run_len;
  cnt_t              sym_len;
  cnt_t              need;
  logic              fill_ok;
  logic              hs;
  logic              is_last;

  expander_p #(
    .DATA_W     (DATA_W),
    .BLOCK_SIZE (BLOCK_SIZE)
  ) u_expander (
    .data    (data_i),
    .dbx     (dbx),
    .is_dbp  (is_dbp),
    .is_run  (is_run),
    .run_len (run_len),
    .sym_len (sym_len)
  );

  assign need    = (state_q == ST_IDLE) ? FULL_LEN : sym_len;
  assign fill_ok = fill_i >= need;
  assign hs      = data_vld_i && fill_ok && rdy_i && !clr_i;
  assign is_last = plane_cnt_q == LAST_PLANE;
  assign dbp     = is_dbp ? '0 : (dbx ^ dbp_q);

  // Outputs are decoded straight from state and window so a beat costs no latency.
  always_comb begin
    vld_o      = 1'b0;
    data_rdy_o = 1'b0;
    len_o      = FULL_LEN;
    data_o     = data_i;
    base_o     = 1'b0;
    last_o     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        vld_o      = data_vld_i && fill_ok;
        data_rdy_o = rdy_i && fill_ok;
        base_o     = 1'b1;
      end
      ST_PLANE: begin
        vld_o      = data_vld_i && fill_ok;
        data_rdy_o = rdy_i && fill_ok;
        len_o      = sym_len;
        data_o     = dbp;
        last_o     = is_last;
      end
      ST_RUN: begin
        vld_o  = 1'b1;
        len_o  = '0;
        data_o = dbp_q;
        last_o = is_last;
      end
      default: begin
        vld_o = 1'b0;
      end
    endcase
    if (clr_i || !rst_ni) begin
      vld_o      = 1'b0;
      data_rdy_o = 1'b0;
    end
    if (!rst_ni) begin
      base_o = 1'b0;
      last_o = 1'b0;
    end
  end

  // Reaching the last plane ends the block even if a zero run still has planes left.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      plane_cnt_q <= '0;
      run_cnt_q   <= '0;
      dbp_q       <= '0;
    end else if (clr_i) begin
      state_q     <= ST_IDLE;
      plane_cnt_q <= '0;
      run_cnt_q   <= '0;
      dbp_q       <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (hs) begin
            state_q     <= ST_PLANE;
            plane_cnt_q <= '0;
          end
        end
        ST_PLANE: begin
          if (hs) begin
            if (is_last) begin
              state_q     <= ST_IDLE;
              plane_cnt_q <= '0;
              run_cnt_q   <= '0;
              dbp_q       <= '0;
            end else begin
              plane_cnt_q <= plane_cnt_q + 1'b1;
              dbp_q       <= dbp;
              if (is_run && run_len != '0) begin
                run_cnt_q <= run_len;
                state_q   <= ST_RUN;
              end
            end
          end
        end
        ST_RUN: begin
          if (rdy_i) begin
            if (is_last) begin
              state_q     <= ST_IDLE;
              plane_cnt_q <= '0;
              run_cnt_q   <= '0;
              dbp_q       <= '0;
            end else begin
              plane_cnt_q <= plane_cnt_q + 1'b1;
              run_cnt_q   <= run_cnt_q - 1'b1;
              if (run_cnt_q == cnt_t'(1)) state_q <= ST_PLANE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef SYMBOL_DECODER_ERR_EN
  localparam int unsigned LOG_N = $clog2(BLOCK_SIZE - 1);

  logic pair_oob;
  logic err_set;

  assign pair_oob = (data_i[DATA_W-1 -: 5] == CODE_PAIR) &&
                    (data_i[DATA_W-6 -: LOG_N] == LOG_N'(BLOCK_SIZE - 2));
  assign err_set  = (state_q == ST_PLANE && hs && (pair_oob || (is_run && is_last))) ||
                    (state_q == ST_RUN && rdy_i && is_last && run_cnt_q != cnt_t'(1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)      err_o <= 1'b0;
    else if (clr_i)   err_o <= 1'b0;
    else if (err_set) err_o <= 1'b1;
  end
`endif

endmodule
